hazard_unit_mc: RTL

//  Parametrised successor hazard/forwarding controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
//  - Resolves RAW hazards by M/W->E forwarding.
//  - Inserts a programmable number of load-use bubbles, matching data-memory latency.
//  - Squashes wrong-path instructions on a taken branch.
//  - Freezes the pipe around a multi-cycle mul/div unit (MDU), with a watchdog.

---
 rtl/hazard_unit_mc_if.sv | 50 +++++
 rtl/hazard_unit_mc.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc_if.sv
//------------------------------------------------------------------------------
// hazard_unit_mc_if : datapath <-> hazard controller signal bundle.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_unit_mc_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  RegWriteE;
  logic                  RegWriteM;
  logic                  RegWriteW;
  logic                  ResultSrcE;
  logic                  PcSrcE;
  logic                  MduStartE;
  logic                  MduDoneE;
  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;
  logic [REG_ADDR_W-1:0] Rs1E;
  logic [REG_ADDR_W-1:0] Rs2E;
  logic [REG_ADDR_W-1:0] RdE;
  logic [REG_ADDR_W-1:0] RdM;
  logic [REG_ADDR_W-1:0] RdW;
  logic                  StallF;
  logic                  StallD;
  logic                  StallE;
  logic                  FlushD;
  logic                  FlushE;
  logic                  FlushM;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic [1:0]            HazState;
  logic                  MduErr;

  modport master (
    output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PcSrcE, MduStartE, MduDoneE,
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, HazState, MduErr
  );

  modport slave (
    input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PcSrcE, MduStartE, MduDoneE,
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, HazState, MduErr
  );
endinterface

`default_nettype wire

// File: rtl/hazard_unit_mc.sv
//------------------------------------------------------------------------------
// hazard_unit_mc : forwarding, load-use, branch-flush and MDU-freeze control
// for a 5-stage RISC-V pipeline.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_unit_mc #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MDU_TIMEOUT       = 64
) (
  input  wire logic       clk,
  input  wire logic       reset,
  hazard_unit_mc_if.slave hz
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD_WAIT = 2'b01,
    ST_MDU_BUSY  = 2'b10
  } state_t;

  localparam int                    CNT_W         = 3;
  localparam int                    WD_W          = $clog2(MDU_TIMEOUT + 1);
  localparam logic [REG_ADDR_W-1:0] C_ZERO_REG    = '0;
  localparam logic [CNT_W-1:0]      C_LOAD_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [WD_W-1:0]       C_WDOG_LIMIT  = WD_W'(MDU_TIMEOUT);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WD_W-1:0]  r_wdog, w_wdog_nxt;
  logic             r_mdu_err, w_mdu_err_nxt;

  logic             w_lwstall;
  logic             w_stall_fd, w_stall_e;
  logic             w_flush_d, w_flush_e, w_flush_m;
  logic [1:0]       w_fwd_a, w_fwd_b;

  // M-stage result is younger than W, so it wins when both match.
  always_comb begin
    w_fwd_a = 2'b00;
    if (hz.RegWriteM && hz.Rs1E != C_ZERO_REG && hz.Rs1E == hz.RdM)
      w_fwd_a = 2'b10;
    else if (hz.RegWriteW && hz.Rs1E != C_ZERO_REG && hz.Rs1E == hz.RdW)
      w_fwd_a = 2'b01;

    w_fwd_b = 2'b00;
    if (hz.RegWriteM && hz.Rs2E != C_ZERO_REG && hz.Rs2E == hz.RdM)
      w_fwd_b = 2'b10;
    else if (hz.RegWriteW && hz.Rs2E != C_ZERO_REG && hz.Rs2E == hz.RdW)
      w_fwd_b = 2'b01;
  end

  assign w_lwstall = hz.ResultSrcE && hz.RegWriteE && hz.RdE != C_ZERO_REG &&
                     (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_wdog    <= '0;
      r_mdu_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wdog    <= w_wdog_nxt;
      r_mdu_err <= w_mdu_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wdog_nxt    = r_wdog;
    w_mdu_err_nxt = r_mdu_err;
    w_stall_fd    = 1'b0;
    w_stall_e     = 1'b0;
    w_flush_d     = 1'b0;
    w_flush_e     = 1'b0;
    w_flush_m     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (hz.MduStartE && !hz.MduDoneE) begin
          w_stall_fd  = 1'b1;
          w_stall_e   = 1'b1;
          w_flush_m   = 1'b1;
          w_wdog_nxt  = WD_W'(1);
          w_state_nxt = ST_MDU_BUSY;
        end else if (hz.PcSrcE) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (w_lwstall) begin
          w_stall_fd = 1'b1;
          w_flush_e  = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_cnt_nxt   = C_LOAD_RELOAD;
            w_state_nxt = ST_LOAD_WAIT;
          end
        end
      end

      // E holds a bubble here, so branch resolution cannot occur.
      ST_LOAD_WAIT: begin
        w_stall_fd = 1'b1;
        w_flush_e  = 1'b1;
        w_cnt_nxt  = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1))
          w_state_nxt = ST_IDLE;
      end

      ST_MDU_BUSY: begin
        if (hz.MduDoneE) begin
          w_wdog_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_wdog == C_WDOG_LIMIT) begin
          w_mdu_err_nxt = 1'b1;
          w_wdog_nxt    = '0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_stall_fd = 1'b1;
          w_stall_e  = 1'b1;
          w_flush_m  = 1'b1;
          w_wdog_nxt = r_wdog + WD_W'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs are forced quiet for as long as reset is held.
  assign hz.StallF    = w_stall_fd & ~reset;
  assign hz.StallD    = w_stall_fd & ~reset;
  assign hz.StallE    = w_stall_e  & ~reset;
  assign hz.FlushD    = w_flush_d  & ~reset;
  assign hz.FlushE    = w_flush_e  & ~reset;
  assign hz.FlushM    = w_flush_m  & ~reset;
  assign hz.ForwardAE = reset ? 2'b00 : w_fwd_a;
  assign hz.ForwardBE = reset ? 2'b00 : w_fwd_b;
  assign hz.HazState  = r_state;
  assign hz.MduErr    = r_mdu_err;

endmodule

`default_nettype wire
